// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate enable, x/y counters, registered HSYNC/VSYNC/video_on.
// Optional macro VGA_FRAME_TICK_EN enables the registered frame_tick strobe; otherwise it is tied to 0.
module vga_sync_gen #(
   parameter int CLK_DIV = 4,
   parameter int H_DISP  = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_DISP  = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       p_tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_FIRST = 10'(H_DISP + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_DISP + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISP);
   localparam logic [9:0] V_VIS    = 10'(V_DISP);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             p_tick_q;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic             pix_adv;

   assign pix_adv = (div_q == DIV_LAST);

   always_comb begin
      div_d = pix_adv ? '0 : div_q + 1'b1;
   end

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (pix_adv) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   // Decode from next-state coordinates so sync/blank switch on the same edge as x/y.
   always_comb begin
      hsync_d    = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
      vsync_d    = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
      video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         p_tick_q   <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b1;
      end else begin
         div_q      <= div_d;
         x_q        <= x_d;
         y_q        <= y_d;
         p_tick_q   <= pix_adv;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
      end
   end

`ifdef VGA_FRAME_TICK_EN
   logic frame_tick_q, frame_tick_d;

   always_comb begin
      frame_tick_d = pix_adv && (x_q == H_LAST) && (y_q == V_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= frame_tick_d;
      end
   end

   assign frame_tick = frame_tick_q;
`else
   assign frame_tick = 1'b0;
`endif

   assign p_tick   = p_tick_q;
   assign x        = x_q;
   assign y        = y_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = video_on_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: instance 0 uses the 640x480 timing, instance 1 a shrunken raster so whole frames fit.
module tb_vga_sync_gen;

   // Instance 0: full-size timing; instance 1: tiny raster with the minimum divider.
   localparam int D0 = 4, HD0 = 640, HF0 = 16, HS0 = 96, HB0 = 48, VD0 = 480, VF0 = 10, VS0 = 2, VB0 = 33;
   localparam int D1 = 2, HD1 = 20,  HF1 = 3,  HS1 = 5,  HB1 = 4,  VD1 = 12,  VF1 = 2,  VS1 = 2, VB1 = 3;

   localparam int P_DIV[2] = '{D0, D1};
   localparam int P_HD[2]  = '{HD0, HD1};
   localparam int P_HF[2]  = '{HF0, HF1};
   localparam int P_HS[2]  = '{HS0, HS1};
   localparam int P_HB[2]  = '{HB0, HB1};
   localparam int P_VD[2]  = '{VD0, VD1};
   localparam int P_VF[2]  = '{VF0, VF1};
   localparam int P_VS[2]  = '{VS0, VS1};
   localparam int P_VB[2]  = '{VB0, VB1};

   typedef struct {
      int edge_no;
      int x;
      int y;
      int hs;
      int vs;
      int von;
      int ft;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pt[2];
   logic [9:0] xo[2];
   logic [9:0] yo[2];
   logic       hso[2];
   logic       vso[2];
   logic       vono[2];
   logic       fto[2];

   exp_t sbq[2][$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   gcount  = 0;
   int   last_rst = 0;
   int   k       = 0;
   int   prev_vec[2];

   always #5 clk = ~clk;

   vga_sync_gen #(.CLK_DIV(D0), .H_DISP(HD0), .H_FP(HF0), .H_SYNC(HS0), .H_BP(HB0),
                  .V_DISP(VD0), .V_FP(VF0), .V_SYNC(VS0), .V_BP(VB0)) dut0 (
      .clk(clk), .rst_n(rst_n), .p_tick(pt[0]), .x(xo[0]), .y(yo[0]),
      .hsync(hso[0]), .vsync(vso[0]), .video_on(vono[0]), .frame_tick(fto[0]));

   vga_sync_gen #(.CLK_DIV(D1), .H_DISP(HD1), .H_FP(HF1), .H_SYNC(HS1), .H_BP(HB1),
                  .V_DISP(VD1), .V_FP(VF1), .V_SYNC(VS1), .V_BP(VB1)) dut1 (
      .clk(clk), .rst_n(rst_n), .p_tick(pt[1]), .x(xo[1]), .y(yo[1]),
      .hsync(hso[1]), .vsync(vso[1]), .video_on(vono[1]), .frame_tick(fto[1]));

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Reference: n-th pixel advance since reset lands on raster position n mod (HT*VT).
   function automatic exp_t model(input int i, input int kk);
      exp_t e;
      int ht, vt, n, f;
      ht = P_HD[i] + P_HF[i] + P_HS[i] + P_HB[i];
      vt = P_VD[i] + P_VF[i] + P_VS[i] + P_VB[i];
      n  = kk / P_DIV[i];
      f  = n % (ht * vt);
      e.edge_no = 0;
      e.x   = f % ht;
      e.y   = f / ht;
      e.hs  = (e.x >= P_HD[i] + P_HF[i] && e.x < P_HD[i] + P_HF[i] + P_HS[i]) ? 0 : 1;
      e.vs  = (e.y >= P_VD[i] + P_VF[i] && e.y < P_VD[i] + P_VF[i] + P_VS[i]) ? 0 : 1;
      e.von = (e.x < P_HD[i] && e.y < P_VD[i]) ? 1 : 0;
`ifdef VGA_FRAME_TICK_EN
      e.ft  = (f == 0) ? 1 : 0;
`else
      e.ft  = 0;
`endif
      return e;
   endfunction

   task automatic step(input logic r);
      exp_t e;
      @(negedge clk);
      rst_n = r;
      @(posedge clk);
      gcount++;
      if (!r) begin
         k = 0;
         last_rst = gcount;
         #1;
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d_x", i), int'(xo[i]), 0);
            chk($sformatf("rst%0d_y", i), int'(yo[i]), 0);
            chk($sformatf("rst%0d_ctl", i),
                int'({pt[i], hso[i], vso[i], vono[i], fto[i]}), int'(5'b01110));
         end
      end else begin
         k++;
         for (int i = 0; i < 2; i++) begin
            if (k % P_DIV[i] == 0) begin
               e = model(i, k);
               e.edge_no = gcount;
               sbq[i].push_back(e);
            end
         end
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) step(1'b1);
   endtask

   // Monitor: p_tick is the valid strobe; between ticks everything must hold.
   always @(negedge clk) begin
      exp_t e;
      int   cur;
      for (int i = 0; i < 2; i++) begin
         cur = int'({xo[i], yo[i], hso[i], vso[i], vono[i], fto[i]});
         if (pt[i] === 1'b1) begin
            if (sbq[i].size() == 0) begin
               chk($sformatf("u%0d_unexpected_ptick_edge%0d", i, gcount), 1, 0);
            end else begin
               e = sbq[i].pop_front();
               $display("[TB] u%0d edge %0d: x=%0d y=%0d hs=%0b vs=%0b von=%0b ft=%0b", i, gcount,
                        xo[i], yo[i], hso[i], vso[i], vono[i], fto[i]);
               chk($sformatf("u%0d_ptick_edge", i), gcount, e.edge_no);
               chk($sformatf("u%0d_x", i), int'(xo[i]), e.x);
               chk($sformatf("u%0d_y", i), int'(yo[i]), e.y);
               chk($sformatf("u%0d_hsync@%0d,%0d", i, e.x, e.y), int'(hso[i]), e.hs);
               chk($sformatf("u%0d_vsync@%0d,%0d", i, e.x, e.y), int'(vso[i]), e.vs);
               chk($sformatf("u%0d_video_on@%0d,%0d", i, e.x, e.y), int'(vono[i]), e.von);
               chk($sformatf("u%0d_frame_tick@%0d,%0d", i, e.x, e.y), int'(fto[i]), e.ft);
            end
         end else if (gcount > 0 && gcount != last_rst) begin
            chk($sformatf("u%0d_hold_edge%0d", i, gcount), cur, prev_vec[i] & ~1);
         end
         prev_vec[i] = cur;
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) step(1'b0);
      // Long run: crosses a full 800-pixel line on instance 0, several frames on instance 1.
      run(4200);
      for (int it = 0; it < 6; it++) begin
         int rl;
         rl = $urandom_range(3, 1);
         for (int c = 0; c < rl; c++) step(1'b0);
         run($urandom_range(3000, 100));
      end
      step(1'b0);
      run(2600);
      @(negedge clk);
      #1;
      chk("u0_queue_drained", sbq[0].size(), 0);
      chk("u1_queue_drained", sbq[1].size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator for the 640x480 display path.
- Derives a pixel-rate enable from the system clock.
- Runs horizontal and vertical position counters and produces HSYNC/VSYNC/blanking.
- Supplies the 10-bit x/y coordinates that drive every downstream sprite/shape decoder (arrow, goose, obstacles, score) and the colour mux.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 2..16
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk, input, 1, system clock; all state on rising edge
- rst_n, input, 1, synchronous reset, active low
- p_tick, output, 1, one-clk pulse marking each pixel advance
- x, output, 10, current horizontal position, 0..H_TOTAL-1
- y, output, 10, current vertical position, 0..V_TOTAL-1
- hsync, output, 1, horizontal sync, active low
- vsync, output, 1, vertical sync, active low
- video_on, output, 1, high when (x,y) is in the visible area
- frame_tick, output, 1, one-clk pulse at start of frame (optional feature)

Behaviour:
- H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP = 525.
- Reset: synchronous, active low, sampled on rising clk. While rst_n=0 on an edge, the block loads:
  - divider=0, x=0, y=0
  - hsync=1, vsync=1, video_on=1, p_tick=0, frame_tick=0
- Reset asserted mid-frame has the same effect; no partial line completes.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - p_tick is registered; it is 1 for exactly the clk cycle following the edge on which divider == CLK_DIV-1, and 0 otherwise.
  - The first p_tick after reset release appears CLK_DIV clks after the first non-reset edge.
- Counters: they advance only on an edge where the divider wraps, i.e. the same edge that raises p_tick.
  - x increments by 1. When x == H_TOTAL-1, x goes to 0 and y advances.
  - y increments by 1. When y == V_TOTAL-1 together with an x wrap, y goes to 0.
  - Simultaneous x and y wrap (799,524) -> (0,0) happens on a single edge.
  - Both counters are 10-bit unsigned; values are never >= their TOTAL.
- Sync/blank outputs are registered and computed from the next-state x/y, so they change on the same edge as x/y (zero skew vs coordinates).
  - hsync = 0 iff H_DISP+H_FP <= x <= H_DISP+H_FP+H_SYNC-1 (656..751).
  - vsync = 0 iff V_DISP+V_FP <= y <= V_DISP+V_FP+V_SYNC-1 (490..491).
  - video_on = 1 iff x < H_DISP and y < V_DISP.
- Between pixel advances all of x, y, hsync, vsync and video_on hold steady.
- Downstream decoders are combinational on x/y and may use x/y directly; colour output is gated by video_on.

Optional Feature:
- Macro: VGA_FRAME_TICK_EN.
- Defined: frame_tick is a registered one-clk pulse, high in the same cycle as the p_tick whose edge moved (x,y) from (799,524) to (0,0).
  - No pulse on reset release.
  - Exactly one pulse per 420000 p_ticks.
  - Game-logic modules use it as their update strobe.
- Not defined: the frame_tick port remains present, tied to 0; no frame-detect logic is synthesised.

Test Plan:
- Reset then release, CLK_DIV=4 -> p_tick pulses at clk 4, 8, 12, ... after release, each 1 clk wide. x steps 0->1->2 on those edges; y=0. hsync, vsync and video_on all 1.
- Run one line -> at x=640 video_on=0; at x=656 hsync=0; hsync stays 0 through x=751 and returns to 1 at x=752. After x=799, x=0 and y=1 on the same edge.
- Run a full frame -> at y=480 video_on=0 for the whole line; vsync=0 only for y=490 and y=491. (799,524)->(0,0) on one edge, and the period is 800*525*4 = 1,680,000 clks.
- Define VGA_FRAME_TICK_EN, run 2 frames -> exactly 2 frame_tick pulses, 1,680,000 clks apart, each coincident with p_tick at the (0,0) transition. Without the macro, frame_tick stays 0 throughout.
- Assert rst_n=0 for 1 clk at (x=700,y=300, hsync=0) -> next edge gives x=0, y=0, hsync=1, p_tick=0. Timing restarts exactly as after power-on reset.
- Sample x, y and video_on on each p_tick -> for every one of the 420000 positions, video_on == (x<640 && y<480). Consecutive values of x/y never repeat or skip within a frame.
